cfg_stream_loader: RTL

CFG_STREAM_LOADER -- requirements
Module: cfg_stream_loader

---
 rtl/cfg_stream_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/cfg_stream_loader.sv
// Configuration stream loader: parses HEADER, N, then N {IDX, REG, DATA} records
// from a byte stream and issues one single-byte register write per record.
module cfg_stream_loader #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        valid,
  input  logic        ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  rec_count
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_COUNT,
    S_IDX,
    S_REG,
    S_DATA,
    S_WRITE
  } state_t;

  // Last wait-counter value before giving up on the peripheral.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] n_rec;
  logic [2:0] idx_q;
  logic [7:0] reg_q;
  logic [7:0] wait_cnt;
  logic [7:0] rec_next;
  logic       accept;

  assign accept   = in_valid && in_ready;
  assign rec_next = rec_count + 8'd1;
  assign busy     = (state != S_HUNT);

  // Frame fields carry no control meaning until the state machine consumes them.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (state)
        S_COUNT: n_rec <= in_data;
        S_IDX:   idx_q <= in_data[2:0];
        S_REG:   reg_q <= in_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HUNT;
      in_ready  <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      valid     <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rec_count <= '0;
      wait_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_HUNT: begin
          in_ready <= 1'b1;
          if (accept && (in_data == HEADER)) begin
            state     <= S_COUNT;
            err       <= 1'b0;
            rec_count <= '0;
          end
        end
        S_COUNT: begin
          if (accept) begin
            if (in_data == 8'd0) begin
              done  <= 1'b1;
              state <= S_HUNT;
            end else begin
              state <= S_IDX;
            end
          end
        end
        S_IDX: begin
          if (accept) state <= S_REG;
        end
        S_REG: begin
          if (accept) state <= S_DATA;
        end
        S_DATA: begin
          if (accept) begin
            addr     <= {5'b0, idx_q, reg_q};
            wdata    <= {24'b0, in_data};
            wstrb    <= 4'b0001;
            valid    <= 1'b1;
            wait_cnt <= '0;
            in_ready <= 1'b0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          // An acknowledge on the final waiting cycle still counts as a completed write.
          if (ready) begin
            valid     <= 1'b0;
            wstrb     <= '0;
            in_ready  <= 1'b1;
            rec_count <= rec_next;
            if (rec_next == n_rec) begin
              done  <= 1'b1;
              state <= S_HUNT;
            end else begin
              state <= S_IDX;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            valid    <= 1'b0;
            wstrb    <= '0;
            in_ready <= 1'b1;
            err      <= 1'b1;
            state    <= S_HUNT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= S_HUNT;
      endcase
    end
  end

endmodule
